// File: rtl/csrng_app_sequencer.sv
// CSRNG application-port sequencer: UNI/INS bring-up, round-robin GEN service, periodic RES.
// Optional macro CSRNG_APP_SEQUENCER_FIPS_CHK_EN adds genbits_fips_i and discards non-FIPS words.
module csrng_app_sequencer #(
  parameter int NumReq         = 2,
  parameter int SeedWords      = 12,
  parameter int ReseedInterval = 16
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            enable_i,
  input  logic [(SeedWords > 0 ? SeedWords*32 : 32)-1:0]  seed_i,
  input  logic [NumReq-1:0]                               req_i,
  output logic [NumReq-1:0]                               gnt_o,
  output logic [127:0]                                    data_o,
  output logic                                            ready_o,
  output logic                                            err_o,
  output logic                                            csrng_req_valid_o,
  input  logic                                            csrng_req_ready_i,
  output logic [31:0]                                     csrng_req_bus_o,
  input  logic                                            csrng_rsp_ack_i,
  input  logic                                            csrng_rsp_sts_i,
  input  logic                                            genbits_valid_i,
  input  logic [127:0]                                    genbits_bus_i,
`ifdef CSRNG_APP_SEQUENCER_FIPS_CHK_EN
  input  logic                                            genbits_fips_i,
`endif
  output logic                                            genbits_ready_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [3:0]  LastWord = 4'((SeedWords > 0) ? SeedWords - 1 : 0);
  localparam logic [31:0] HdrUni   = 32'h0000_0005;
  localparam logic [31:0] HdrRes   = 32'h0000_0002;
  localparam logic [31:0] HdrGen   = 32'h0000_1003;
  localparam logic [31:0] HdrIns   = {20'h0, 4'(SeedWords), 4'h1};

  typedef enum logic [3:0] {
    IDLE, UNI_HDR, UNI_ACK, INS_HDR, INS_DATA, INS_ACK, READY,
    GEN_HDR, GEN_BITS, GEN_ACK, RES_HDR, RES_ACK, ERROR
  } state_e;

  state_e          state, state_d;
  logic [3:0]      word_idx, word_idx_d;
  logic [7:0]      reseed_cnt;
  logic [PtrW-1:0] ptr, winner, rr_winner;
  logic            req_xfer, gb_xfer, deliver, word_ok, retry_last;

  assign req_xfer = csrng_req_valid_o & csrng_req_ready_i;
  assign gb_xfer  = genbits_valid_i & genbits_ready_o;
  assign deliver  = (state == GEN_BITS) & gb_xfer & word_ok;

`ifdef CSRNG_APP_SEQUENCER_FIPS_CHK_EN
  logic [3:0] retry_cnt;
  assign word_ok    = genbits_fips_i;
  assign retry_last = (retry_cnt == 4'd3);
`else
  assign word_ok    = 1'b1;
  assign retry_last = 1'b0;
`endif

  // Farthest candidate first so the one nearest the pointer overrides it.
  always_comb begin
    rr_winner = ptr;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr) + i) % NumReq]) rr_winner = PtrW'((int'(ptr) + i) % NumReq);
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state;
    word_idx_d = word_idx;
    unique case (state)
      IDLE:     if (enable_i) state_d = UNI_HDR;
      UNI_HDR:  if (req_xfer) state_d = UNI_ACK;
      UNI_ACK:  if (csrng_rsp_ack_i) state_d = csrng_rsp_sts_i ? ERROR : INS_HDR;
      INS_HDR: begin
        if (req_xfer) begin
          state_d    = (SeedWords == 0) ? INS_ACK : INS_DATA;
          word_idx_d = '0;
        end
      end
      INS_DATA: begin
        if (req_xfer) begin
          if (word_idx == LastWord) state_d = INS_ACK;
          else word_idx_d = word_idx + 1'b1;
        end
      end
      INS_ACK:  if (csrng_rsp_ack_i) state_d = csrng_rsp_sts_i ? ERROR : READY;
      READY: begin
        if (!enable_i) state_d = IDLE;
        else if (reseed_cnt == 8'(ReseedInterval)) state_d = RES_HDR;
        else if (|req_i) state_d = GEN_HDR;
      end
      GEN_HDR:  if (req_xfer) state_d = GEN_BITS;
      GEN_BITS: begin
        if (gb_xfer) begin
          if (csrng_rsp_ack_i && csrng_rsp_sts_i) state_d = ERROR;
          else if (!word_ok) state_d = retry_last ? ERROR : GEN_HDR;
          else if (csrng_rsp_ack_i) state_d = READY;
          else state_d = GEN_ACK;
        end else if (csrng_rsp_ack_i) begin
          state_d = ERROR;
        end
      end
      GEN_ACK:  if (csrng_rsp_ack_i) state_d = csrng_rsp_sts_i ? ERROR : READY;
      RES_HDR:  if (req_xfer) state_d = RES_ACK;
      RES_ACK:  if (csrng_rsp_ack_i) state_d = csrng_rsp_sts_i ? ERROR : READY;
      ERROR:    if (!enable_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: state and every output are registers updated with non-blocking assignments,
  // and the asynchronous reset clears all of them in the same cycle it asserts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      word_idx          <= '0;
      reseed_cnt        <= '0;
      ptr               <= '0;
      winner            <= '0;
      gnt_o             <= '0;
      data_o            <= '0;
      ready_o           <= 1'b0;
      err_o             <= 1'b0;
      csrng_req_valid_o <= 1'b0;
      csrng_req_bus_o   <= '0;
      genbits_ready_o   <= 1'b0;
`ifdef CSRNG_APP_SEQUENCER_FIPS_CHK_EN
      retry_cnt         <= '0;
`endif
    end else begin
      state    <= state_d;
      word_idx <= word_idx_d;

      if (state_d == READY && (state == INS_ACK || state == RES_ACK)) reseed_cnt <= '0;
      else if (state_d == READY && (state == GEN_BITS || state == GEN_ACK)) reseed_cnt <= reseed_cnt + 1'b1;

      if (state == READY && state_d == GEN_HDR) winner <= rr_winner;

      gnt_o <= '0;
      if (deliver) begin
        gnt_o  <= NumReq'(1) << winner;
        data_o <= genbits_bus_i;
        ptr    <= (winner == PtrW'(NumReq - 1)) ? '0 : winner + 1'b1;
      end

`ifdef CSRNG_APP_SEQUENCER_FIPS_CHK_EN
      if (state == READY) retry_cnt <= '0;
      else if (state == GEN_BITS && gb_xfer) retry_cnt <= word_ok ? '0 : retry_cnt + 1'b1;
`endif

      ready_o           <= (state_d == READY);
      err_o             <= (state_d == ERROR);
      genbits_ready_o   <= (state_d == GEN_BITS);
      csrng_req_valid_o <= (state_d inside {UNI_HDR, INS_HDR, INS_DATA, GEN_HDR, RES_HDR});
      unique case (state_d)
        UNI_HDR:  csrng_req_bus_o <= HdrUni;
        INS_HDR:  csrng_req_bus_o <= HdrIns;
        INS_DATA: csrng_req_bus_o <= seed_i[32*int'(word_idx_d) +: 32];
        GEN_HDR:  csrng_req_bus_o <= HdrGen;
        RES_HDR:  csrng_req_bus_o <= HdrRes;
        default:  csrng_req_bus_o <= '0;
      endcase
    end
  end

endmodule
